// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - round-robin N-channel registered mux; optional RR_MUX_FIXED_PRIO_EN adds fixed_prio
module rr_mux_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef RR_MUX_FIXED_PRIO_EN
    input  logic                          fixed_prio,
`endif
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CHANNELS)-1:0]   out_sel
);

    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   grant_idx;
    logic               load;
    logic               ptr_en;
    logic [WIDTH-1:0]   chan [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
        assign chan[c] = in_data[c*WIDTH +: WIDTH];
    end

    assign out_valid = (state_q == FULL);

    // A word is taken whenever someone is valid and the output slot is free or draining;
    // reset suppresses acceptance so no producer sees a handshake while reset is high.
    assign load = (|in_valid) && (!out_valid || out_ready) && !reset;

    assign in_ready = load ? (CHANNELS'(1) << grant_idx) : '0;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign ptr_en = load && !fixed_prio;
`else
    assign ptr_en = load;
`endif

    // Arbitration: pick the valid channel closest after ptr (ptr itself is searched last).
    always_comb begin
        int best_d;
        int d;
        grant_idx = '0;
        best_d    = CHANNELS;
        d         = 0;
`ifdef RR_MUX_FIXED_PRIO_EN
        if (fixed_prio) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_idx = SEL_W'(i);
                end
            end
        end else
`endif
        begin
            for (int i = 0; i < CHANNELS; i++) begin
                d = i - int'(ptr_q) - 1;
                if (d < 0) begin
                    d = d + CHANNELS;
                end
                if (in_valid[i] && (d < best_d)) begin
                    best_d    = d;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

    // Output slot state: EMPTY/FULL next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State register; reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source tag and round-robin pointer capture on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr_q    <= SEL_W'(CHANNELS - 1);
        end else begin
            if (load) begin
                out_data <= chan[grant_idx];
                out_sel  <= grant_idx;
            end
            if (ptr_en) begin
                ptr_q <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - scoreboard bench for rr_mux_n (4 channels x 16 bits)
module tb_rr_mux_n;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_sel;

    always #5 clk = ~clk;

    rr_mux_n #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } item_t;

    item_t        sb_q[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] pend_data [N];
    logic [N-1:0] pend;
    logic         auto_refill;
    logic [1:0]   m_ptr;
    logic         m_full;
    logic [W-1:0] m_data;
    logic [1:0]   m_sel;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, update the reference model.
    task automatic cycle(input logic rst, input logic ordy);
        logic         ld;
        logic [1:0]   g;
        logic         found;
        logic [N-1:0] exp_rdy;
        item_t        it;
        reset     = rst;
        out_ready = ordy;
        in_valid  = pend;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = pend_data[i];
        end
        #1;
        check_val("out_valid", 64'(out_valid), 64'(m_full));
        check_val("out_data", 64'(out_data), 64'(m_data));
        check_val("out_sel", 64'(out_sel), 64'(m_sel));
        found = 1'b0;
        g     = 2'd0;
        for (int k = 1; k <= N; k++) begin
            logic [1:0] idx;
            idx = m_ptr + 2'(k);
            if (!found && pend[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        ld      = found && (!m_full || ordy) && !rst;
        exp_rdy = ld ? (4'b0001 << g) : 4'b0000;
        check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (rst) begin
            sb_q.delete();
            m_full = 1'b0;
            m_ptr  = 2'd3;
            m_data = '0;
            m_sel  = '0;
        end else begin
            if (m_full && ordy) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_empty", 64'd1, 64'd0);
                end else begin
                    it = sb_q.pop_front();
                    check_val("drain_data", 64'(out_data), 64'(it.data));
                    check_val("drain_sel", 64'(out_sel), 64'(it.sel));
                end
                m_full = 1'b0;
            end
            if (ld) begin
                it.data = pend_data[g];
                it.sel  = g;
                sb_q.push_back(it);
                m_full  = 1'b1;
                m_ptr   = g;
                m_data  = pend_data[g];
                m_sel   = g;
                pend[g] = auto_refill;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        pend        = '0;
        auto_refill = 1'b0;
        for (int i = 0; i < N; i++) pend_data[i] = '0;
        m_full    = 1'b0;
        m_ptr     = 2'd3;
        m_data    = '0;
        m_sel     = '0;
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        repeat (2) @(negedge clk);

        // Reset and idle: nothing accepted, outputs at reset values.
        repeat (3) cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);

        // All channels valid, full throughput: grants 0,1,2,3,0,1.
        for (int i = 0; i < N; i++) pend_data[i] = 16'hA00 + 16'(i);
        pend        = 4'hF;
        auto_refill = 1'b1;
        repeat (6) cycle(1'b0, 1'b1);
        auto_refill = 1'b0;
        pend        = '0;
        repeat (2) cycle(1'b0, 1'b1);

        // Single channel with stalled consumer: accepted once, held, then drained.
        pend_data[2] = 16'h1234;
        pend         = 4'b0100;
        cycle(1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Back-to-back replacement without a bubble.
        pend_data[3] = 16'h3333;
        pend         = 4'b1000;
        cycle(1'b0, 1'b0);
        pend_data[1] = 16'h1111;
        pend         = 4'b0010;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Reset while full and stalled, then all valid: first grant is channel 0.
        pend_data[1] = 16'hBEEF;
        pend         = 4'b0010;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < N; i++) pend_data[i] = 16'h5A0 + 16'(i);
        pend = 4'hF;
        repeat (4) cycle(1'b0, 1'b1);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]      = 1'b1;
                    pend_data[i] = 16'($urandom);
                end
            end
            cycle(1'b0, 1'($urandom_range(0, 1)));
        end
        pend = '0;
        repeat (3) cycle(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
